// File: rtl/frame_pos_sampler_if.sv
// Position-sampler bus: raw positions/controls in, sampled positions and frame status out.
// update_valid is a one-cycle strobe with no ready: pos_x/pos_y are valid and
// freshly updated in exactly the cycle it is high, and the consumer cannot stall it.
interface frame_pos_sampler_if #(
  parameter int NUM_CH = 2,
  parameter int W      = 10
);
  logic                frame_sync;
  logic [NUM_CH*W-1:0] raw_x;
  logic [NUM_CH*W-1:0] raw_y;
  logic [NUM_CH-1:0]   smooth_en;
  logic                freeze;
  logic [NUM_CH*W-1:0] pos_x;
  logic [NUM_CH*W-1:0] pos_y;
  logic                frame_tick;
  logic                update_valid;
  logic [15:0]         frame_count;
  logic                dbg_state;

  modport master (
    output frame_sync, raw_x, raw_y, smooth_en, freeze,
    input  pos_x, pos_y, frame_tick, update_valid, frame_count, dbg_state
  );

  modport slave (
    input  frame_sync, raw_x, raw_y, smooth_en, freeze,
    output pos_x, pos_y, frame_tick, update_valid, frame_count, dbg_state
  );
endinterface

// File: rtl/frame_pos_sampler.sv
// Per-frame sampler for NUM_CH X/Y positions: synchronises VGA VS, clamps to the
// visible area and optionally smooths each channel with an exponential moving average.
module frame_pos_sampler #(
  parameter int NUM_CH = 2,
  parameter int W      = 10,
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int SHIFT  = 2
) (
  input logic               Clk,
  input logic               Reset,
  frame_pos_sampler_if.slave bus
);

  localparam logic [W-1:0] X_LIM = W'(X_MAX);
  localparam logic [W-1:0] Y_LIM = W'(Y_MAX);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CAP  = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   cap_en, upd_en;

  logic sync1_q, sync2_q, hist_q, fill1_q, fill2_q, tick_q;

  logic [NUM_CH*W-1:0] cap_x_q, cap_y_q, cap_x_d, cap_y_d;
  logic [NUM_CH*W-1:0] pos_x_q, pos_y_q, pos_x_d, pos_y_d;
  logic                primed_q, upd_valid_q;
  logic [15:0]         frame_count_q;

  function automatic logic [W-1:0] clamp(input logic [W-1:0] v, input logic [W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // One EMA step; the forced +/-1 step guarantees exact convergence without overshoot.
  function automatic logic [W-1:0] ema_step(input logic [W-1:0] pos, input logic [W-1:0] cap);
    logic signed [W:0] d;
    logic signed [W:0] s;
    d = $signed({1'b0, cap}) - $signed({1'b0, pos});
    s = d >>> SHIFT;
    if ((d != '0) && (s == '0)) begin
      s = d[W] ? '1 : (W+1)'(1);
    end
    return pos + s[W-1:0];
  endfunction

  // The zeros loaded at reset are not real VS samples, so the history flop keeps
  // its reset value of 1 until the synchroniser has refilled from the pin.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fill1_q <= 1'b0;
      fill2_q <= 1'b0;
      hist_q  <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= bus.frame_sync;
      sync2_q <= sync1_q;
      fill1_q <= 1'b1;
      fill2_q <= fill1_q;
      if (fill2_q) begin
        hist_q <= sync2_q;
      end
      tick_q <= sync2_q & ~hist_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    upd_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick_q) begin
          cap_en  = 1'b1;
          state_d = ST_CAP;
        end
      end
      ST_CAP: begin
        upd_en  = ~bus.freeze;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cap_x_d = '0;
    cap_y_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cap_x_d[c*W +: W] = clamp(bus.raw_x[c*W +: W], X_LIM);
      cap_y_d[c*W +: W] = clamp(bus.raw_y[c*W +: W], Y_LIM);
    end
  end

  // Until the first real update the filter has no history, so every channel latches directly.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!primed_q || !bus.smooth_en[c]) begin
        pos_x_d[c*W +: W] = cap_x_q[c*W +: W];
        pos_y_d[c*W +: W] = cap_y_q[c*W +: W];
      end else begin
        pos_x_d[c*W +: W] = ema_step(pos_x_q[c*W +: W], cap_x_q[c*W +: W]);
        pos_y_d[c*W +: W] = ema_step(pos_y_q[c*W +: W], cap_y_q[c*W +: W]);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cap_x_q       <= '0;
      cap_y_q       <= '0;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      primed_q      <= 1'b0;
      upd_valid_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      if (cap_en) begin
        cap_x_q       <= cap_x_d;
        cap_y_q       <= cap_y_d;
        frame_count_q <= frame_count_q + 16'd1;
      end
      if (upd_en) begin
        pos_x_q  <= pos_x_d;
        pos_y_q  <= pos_y_d;
        primed_q <= 1'b1;
      end
      upd_valid_q <= upd_en;
    end
  end

  assign bus.pos_x        = pos_x_q;
  assign bus.pos_y        = pos_y_q;
  assign bus.frame_tick   = tick_q;
  assign bus.update_valid = upd_valid_q;
  assign bus.frame_count  = frame_count_q;
  assign bus.dbg_state    = (state_q == ST_CAP);

endmodule
